// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter.
// slave is the arbiter side; master is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a1;
    logic [N_REQ*WIDTH-1:0] req_a2;
    logic [N_REQ*4-1:0]     req_op;
    logic [WIDTH-1:0]       alu_a1;
    logic [WIDTH-1:0]       alu_a2;
    logic [3:0]             alu_ctrl;
    logic [WIDTH-1:0]       alu_out;
    logic                   alu_zero;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_zero;

    modport slave (
        input  req_valid, req_a1, req_a2, req_op, alu_out, alu_zero, rsp_ready,
        output req_ready, alu_a1, alu_a2, alu_ctrl, rsp_valid, rsp_data, rsp_zero
    );

    modport master (
        output req_valid, req_a1, req_a2, req_op, alu_out, alu_zero, rsp_ready,
        input  req_ready, alu_a1, alu_a2, alu_ctrl, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
// One op in flight: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 2
) (
    input logic          clk,
    input logic          reset_n,
    alu_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IdxW:0] NReqW = (IdxW + 1)'(N_REQ);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [WIDTH-1:0]  a1_q, a1_d;
    logic [WIDTH-1:0]  a2_q, a2_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              zero_q, zero_d;

    logic              found;
    logic [IdxW-1:0]   win;
    logic [IdxW:0]     sum;
    logic [WIDTH-1:0]  a1_arr [N_REQ];
    logic [WIDTH-1:0]  a2_arr [N_REQ];
    logic [3:0]        op_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a1_arr[i] = bus.req_a1[i*WIDTH +: WIDTH];
            a2_arr[i] = bus.req_a2[i*WIDTH +: WIDTH];
            op_arr[i] = bus.req_op[i*4 +: 4];
        end
    end

    // First valid requester at or after rr_q, wrapping past N_REQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_q} + (IdxW + 1)'(i);
            if (sum >= NReqW) begin
                sum = sum - NReqW;
            end
            if (!found && bus.req_valid[sum[IdxW-1:0]]) begin
                found = 1'b1;
                win   = sum[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            win_q   <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            op_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            op_q    <= op_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        op_d    = op_q;
        data_d  = data_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    a1_d    = a1_arr[win];
                    a2_d    = a2_arr[win];
                    op_d    = op_arr[win];
                    win_d   = win;
                    rr_d    = (win == LastIdx) ? '0 : win + IdxW'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                data_d  = bus.alu_out;
                zero_d  = bus.alu_zero;
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready[win_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == StIdle && found && reset_n) begin
            bus.req_ready[win] = 1'b1;
        end
        if (state_q == StResp) begin
            bus.rsp_valid[win_q] = 1'b1;
        end
        bus.alu_a1   = a1_q;
        bus.alu_a2   = a2_q;
        bus.alu_ctrl = op_q;
        bus.rsp_data = data_q;
        bus.rsp_zero = zero_q;
    end
endmodule
